// File: rtl/snake_key_input_if.sv
// Key-conditioner bus: raw panel keys and reload toward the block, conditioned
// levels, heading and event pulses back toward the game controller.
interface snake_key_input_if;
    logic [3:0] i_Push;
    logic       i_Start;
    logic       i_Reload;
    logic [3:0] o_Key;
    logic [3:0] o_Direc;
    logic       o_DirValid;
    logic       o_StartPulse;

    modport master (
        output i_Push, i_Start, i_Reload,
        input  o_Key, o_Direc, o_DirValid, o_StartPulse
    );

    modport slave (
        input  i_Push, i_Start, i_Reload,
        output o_Key, o_Direc, o_DirValid, o_StartPulse
    );
endinterface

// File: rtl/snake_key_input.sv
// Snake key conditioner: 2-flop sync, per-key debounce, press events,
// one-hot heading latch with reversal rejection, start pulse.
module snake_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic sync,
    output logic stb,
    output logic press
);
    logic [CNT_W-1:0] cnt;
    logic             diff;
    logic             done;

    assign diff  = sync ^ stb;
    assign done  = diff && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign press = done && sync;

    // Any agreeing cycle restarts the count; the accepting edge clears it too.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt <= '0;
            stb <= 1'b0;
        end else if (done) begin
            cnt <= '0;
            stb <= sync;
        end else if (!diff) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module snake_key_input #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    snake_key_input_if.slave         bus
);
    localparam int         NUM_KEYS  = 5;
    localparam int         KEY_START = 4;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    logic [NUM_KEYS-1:0] raw, sync_q1, sync_q2, stb, press;
    logic [3:0]          direc, win_dir, opp_dir;
    logic                dir_valid, start_pulse, accept;

    // Direction keys are active-low on the panel; internally 1 = pressed.
    assign raw = {bus.i_Start, ~bus.i_Push};

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        snake_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .i_Clk(i_Clk),
            .i_Rst(i_Rst),
            .sync (sync_q2[k]),
            .stb  (stb[k]),
            .press(press[k])
        );
    end

    always_comb begin
        win_dir = '0;
        if      (press[3]) win_dir = DIR_UP;
        else if (press[2]) win_dir = DIR_DOWN;
        else if (press[1]) win_dir = DIR_LEFT;
        else if (press[0]) win_dir = DIR_RIGHT;
    end

    // Swapping within the Up/Down and Left/Right pairs gives the reverse heading.
    assign opp_dir = {direc[2], direc[3], direc[0], direc[1]};
    assign accept  = (|win_dir) && (win_dir != direc) && (win_dir != opp_dir);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            direc       <= DIR_UP;
            dir_valid   <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= press[KEY_START];
            if (bus.i_Reload) begin
                direc     <= DIR_UP;
                dir_valid <= 1'b0;
            end else if (accept) begin
                direc     <= win_dir;
                dir_valid <= 1'b1;
            end else begin
                dir_valid <= 1'b0;
            end
        end
    end

    assign bus.o_Key        = stb[3:0];
    assign bus.o_Direc      = direc;
    assign bus.o_DirValid   = dir_valid;
    assign bus.o_StartPulse = start_pulse;
endmodule

// File: tb/tb_snake_key_input.sv
// Bench for snake_key_input: directed vector table, multi-cycle corner
// sequences and random keys against a sliding-window reference model.
module tb_snake_key_input;
    localparam int DC = 4;

    logic i_Clk, i_Rst;
    snake_key_input_if kif ();

    snake_key_input #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .i_Clk(i_Clk),
        .i_Rst(i_Rst),
        .bus  (kif)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [3:0] push;
        bit         start;
        bit         reload;
        int         cycles;
        logic [3:0] key;
        logic [3:0] direc;
        int         dv;
        int         sp;
    } vec_t;

    int n_chk, n_fail;
    int dv_cnt, sp_cnt, key_nz;

    // Reference model: headings 0 Up, 1 Down, 2 Left, 3 Right; one-hot = 1<<h,
    // key bit for heading h is 3-h, reverse heading is h^1.
    bit m_s0[5], m_s1[5], m_stb[5];
    bit hq[5][$];
    int m_h;
    bit m_dv, m_sp;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [3:0] push, input bit st, input bit rl, input bit rs);
        bit prs[5];
        bit all_diff;
        int w;
        if (rs) begin
            for (int k = 0; k < 5; k++) begin
                m_s0[k] = 0; m_s1[k] = 0; m_stb[k] = 0; hq[k].delete();
            end
            m_h = 0; m_dv = 0; m_sp = 0;
            return;
        end
        // A key level is accepted once the last DC synchronized samples all disagree with it.
        for (int k = 0; k < 5; k++) begin
            hq[k].push_back(m_s1[k]);
            if (hq[k].size() > DC) void'(hq[k].pop_front());
            prs[k]   = 0;
            all_diff = (hq[k].size() == DC);
            for (int i = 0; i < hq[k].size(); i++)
                if (hq[k][i] == m_stb[k]) all_diff = 0;
            if (all_diff) begin
                m_stb[k] = ~m_stb[k];
                prs[k]   = m_stb[k];
            end
        end
        m_sp = prs[4];
        m_dv = 0;
        if (rl) m_h = 0;
        else begin
            w = -1;
            for (int h = 3; h >= 0; h--) if (prs[3-h]) w = h;
            if (w >= 0 && w != m_h && w != (m_h ^ 1)) begin
                m_h  = w;
                m_dv = 1;
            end
        end
        for (int k = 0; k < 5; k++) begin
            m_s1[k] = m_s0[k];
            m_s0[k] = (k < 4) ? ~push[k] : st;
        end
    endtask

    task automatic tick();
        logic [3:0] p;
        logic [3:0] mk;
        bit s, r, rs;
        p = kif.i_Push; s = kif.i_Start; r = kif.i_Reload; rs = i_Rst;
        @(posedge i_Clk);
        model_edge(p, s, r, rs);
        #1;
        mk = {m_stb[3], m_stb[2], m_stb[1], m_stb[0]};
        chk("key",        8'(kif.o_Key),        8'(mk));
        chk("direc",      8'(kif.o_Direc),      8'(4'b0001 << m_h));
        chk("dirvalid",   8'(kif.o_DirValid),   8'(m_dv));
        chk("startpulse", 8'(kif.o_StartPulse), 8'(m_sp));
        dv_cnt += int'(kif.o_DirValid === 1'b1);
        sp_cnt += int'(kif.o_StartPulse === 1'b1);
        key_nz += int'(kif.o_Key !== 4'b0000);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr();
        dv_cnt = 0; sp_cnt = 0; key_nz = 0;
    endtask

    function automatic vec_t mkv(input logic [3:0] p, input bit s, input bit r, input int c,
                                 input logic [3:0] k, input logic [3:0] d, input int dv, input int sp);
        vec_t v;
        v.push = p; v.start = s; v.reload = r; v.cycles = c;
        v.key = k; v.direc = d; v.dv = dv; v.sp = sp;
        return v;
    endfunction

    vec_t tbl[20];

    initial begin
        n_chk = 0; n_fail = 0;
        tbl[0]  = mkv(4'b1111, 0, 0, 20, 4'b0000, 4'b0001, 0, 0);
        tbl[1]  = mkv(4'b1110, 0, 0, 56, 4'b0001, 4'b1000, 1, 0);
        tbl[2]  = mkv(4'b1111, 0, 0, 10, 4'b0000, 4'b1000, 0, 0);
        tbl[3]  = mkv(4'b1011, 0, 0, 10, 4'b0100, 4'b0010, 1, 0);
        tbl[4]  = mkv(4'b1111, 0, 0, 10, 4'b0000, 4'b0010, 0, 0);
        tbl[5]  = mkv(4'b0111, 0, 0, 10, 4'b1000, 4'b0010, 0, 0);
        tbl[6]  = mkv(4'b1111, 0, 0, 10, 4'b0000, 4'b0010, 0, 0);
        tbl[7]  = mkv(4'b1101, 0, 0, 10, 4'b0010, 4'b0100, 1, 0);
        tbl[8]  = mkv(4'b1111, 0, 0, 10, 4'b0000, 4'b0100, 0, 0);
        tbl[9]  = mkv(4'b1100, 0, 0, 10, 4'b0011, 4'b0100, 0, 0);
        tbl[10] = mkv(4'b1111, 0, 0, 10, 4'b0000, 4'b0100, 0, 0);
        tbl[11] = mkv(4'b1111, 0, 1, 10, 4'b0000, 4'b0001, 0, 0);
        tbl[12] = mkv(4'b1011, 0, 0, 10, 4'b0100, 4'b0001, 0, 0);
        tbl[13] = mkv(4'b1111, 0, 0, 10, 4'b0000, 4'b0001, 0, 0);
        tbl[14] = mkv(4'b0111, 0, 0, 10, 4'b1000, 4'b0001, 0, 0);
        tbl[15] = mkv(4'b1111, 0, 0, 10, 4'b0000, 4'b0001, 0, 0);
        tbl[16] = mkv(4'b1100, 0, 0, 10, 4'b0011, 4'b0100, 1, 0);
        tbl[17] = mkv(4'b1111, 0, 0, 10, 4'b0000, 4'b0100, 0, 0);
        tbl[18] = mkv(4'b1111, 1, 0, 10, 4'b0000, 4'b0100, 0, 1);
        tbl[19] = mkv(4'b1111, 0, 0, 10, 4'b0000, 4'b0100, 0, 0);

        kif.i_Push = 4'b1111; kif.i_Start = 1'b0; kif.i_Reload = 1'b0;
        i_Rst = 1'b1;
        ticks(3);
        i_Rst = 1'b0;

        foreach (tbl[i]) begin
            kif.i_Push = tbl[i].push; kif.i_Start = tbl[i].start; kif.i_Reload = tbl[i].reload;
            clr();
            ticks(tbl[i].cycles);
            chk($sformatf("tbl%0d_key", i),   8'(kif.o_Key),   8'(tbl[i].key));
            chk($sformatf("tbl%0d_direc", i), 8'(kif.o_Direc), 8'(tbl[i].direc));
            chk($sformatf("tbl%0d_dv", i),    8'(dv_cnt),      8'(tbl[i].dv));
            chk($sformatf("tbl%0d_sp", i),    8'(sp_cnt),      8'(tbl[i].sp));
        end
        kif.i_Start = 1'b0; kif.i_Reload = 1'b0;

        // Bounce on Left from Up: 3 low / 1 high, five times, then steady.
        kif.i_Reload = 1'b1; tick(); kif.i_Reload = 1'b0;
        clr();
        for (int r = 0; r < 5; r++) begin
            kif.i_Push = 4'b1101; ticks(3);
            kif.i_Push = 4'b1111; tick();
        end
        chk("bounce_key_quiet", 8'(key_nz), 8'd0);
        chk("bounce_no_dv",     8'(dv_cnt), 8'd0);
        kif.i_Push = 4'b1101; clr(); ticks(10);
        chk("bounce_hold_dv",    8'(dv_cnt),        8'd1);
        chk("bounce_hold_direc", 8'(kif.o_Direc),   8'h4);
        kif.i_Push = 4'b1111; ticks(10);

        // Heading Right, then start event coinciding with a reload pulse.
        kif.i_Reload = 1'b1; tick(); kif.i_Reload = 1'b0;
        kif.i_Push = 4'b1110; ticks(10);
        chk("right_direc", 8'(kif.o_Direc), 8'h8);
        kif.i_Push = 4'b1111; ticks(10);
        kif.i_Start = 1'b1; clr(); ticks(5);
        kif.i_Reload = 1'b1; tick(); kif.i_Reload = 1'b0;
        chk("sr_startpulse", 8'(kif.o_StartPulse), 8'd1);
        chk("sr_direc",      8'(kif.o_Direc),      8'h1);
        chk("sr_dirvalid",   8'(kif.o_DirValid),   8'd0);
        ticks(12);
        chk("sr_single_pulse", 8'(sp_cnt), 8'd1);
        kif.i_Start = 1'b0; ticks(10);

        // Reset in the middle of a Left debounce: full debounce again afterwards.
        kif.i_Push = 4'b1101; ticks(4);
        i_Rst = 1'b1; ticks(2); i_Rst = 1'b0;
        clr(); ticks(DC + 1);
        chk("rst_no_early_dv", 8'(dv_cnt), 8'd0);
        tick();
        chk("rst_dv_at_lat",   8'(kif.o_DirValid), 8'd1);
        chk("rst_direc",       8'(kif.o_Direc),    8'h4);
        kif.i_Push = 4'b1111; ticks(10);

        // Random key activity checked cycle by cycle against the model.
        for (int s = 0; s < 300; s++) begin
            kif.i_Push   = 4'($urandom_range(0, 15));
            kif.i_Start  = 1'($urandom_range(0, 1));
            kif.i_Reload = ($urandom_range(0, 15) == 0);
            i_Rst        = ($urandom_range(0, 63) == 0);
            ticks($urandom_range(1, 10));
        end
        i_Rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
